// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// The CPU M-stage port (A) and a secondary master (B) share one access per cycle.
// A bounded starvation counter guarantees B progress under continuous CPU traffic.
// Synchronous read data is routed back to whichever master owned the read.
module dm_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    // CPU port
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    // Secondary master port
    input  logic              b_req,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic [31:0]       b_rdata,
    output logic              b_rvalid,
    // Memory port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        RdNone = 2'd0,
        RdCpu  = 2'd1,
        RdB    = 2'd2
    } rd_owner_e;

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    rd_owner_e         rd_owner_q, rd_owner_d;
    logic              cpu_win;
    logic              b_win;
    logic [ADDR_W-1:0] sel_addr;

    // Grant decision: B wins when alone, or when contended and it has waited long enough.
    always_comb begin
        cpu_win = 1'b0;
        b_win   = 1'b0;
        if (b_req && (!cpu_req || (starve_cnt_q == StarveMax))) begin
            b_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end
    end

    // Memory mux; with no grant the CPU operands pass through but the strobe is off.
    always_comb begin
        sel_addr  = b_win ? b_addr : cpu_addr;
        mem_en    = cpu_win | b_win;
        mem_we    = 4'b0000;
        if (b_win) begin
            mem_we = b_we;
        end else if (cpu_win) begin
            mem_we = cpu_we;
        end
        mem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = b_win ? b_wdata : cpu_wdata;
        b_gnt     = b_win;
        cpu_stall = b_win & cpu_req;
    end

    // Starvation counter and read-owner next state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (b_win) begin
            starve_cnt_d = 4'd0;
        end else if (b_req && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        rd_owner_d = RdNone;
        if (b_win && (b_we == 4'b0000)) begin
            rd_owner_d = RdB;
        end else if (cpu_win && (cpu_we == 4'b0000)) begin
            rd_owner_d = RdCpu;
        end
    end

    // State registers; reset cancels any pending read return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
            rd_owner_q   <= RdNone;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Read return: the memory data arrives in the cycle the owner register names.
    always_comb begin
        cpu_rvalid = (rd_owner_q == RdCpu);
        b_rvalid   = (rd_owner_q == RdB);
        cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
        b_rdata    = b_rvalid   ? mem_rdata : 32'h0;
    end

endmodule
